bin_loader: RTL and testbench

- Boot sequencer for the 12-bit PDP-8 core.
- Holds the core in reset and parses a PDP-8 BIN-format byte stream from a serial receiver.
- Writes decoded words into program memory through a dedicated write port and verifies the tape checksum.
- Releases the core only after a good load. It sits between the UART RX, the shared memory write port and the core's reset input.

---
 rtl/bin_loader.sv | 142 ++++++++++++++
 tb/tb_bin_loader.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_loader.sv
// PDP-8 boot sequencer: holds the core in reset while a BIN-format tape arrives over RX,
// writes the decoded words to program memory, and releases the core after a good checksum.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   WAIT_LEADER | waiting for the first 0x80 leader byte
//   LEADER      | inside leader; 0x80 repeats, a frame byte starts the first pair
//   HI          | expecting the first frame of a pair, or 0x80 trailer
//   LO          | expecting the second frame (00xxxxxx) of a pair
//   DONE        | checksum good; counting down HOLD before releasing the core
//   ERR         | format or checksum error; waits for reset
module bin_loader #(
    parameter logic       BYPASS = 1'b0,
    parameter logic [3:0] HOLD   = 4'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        mem_we,
    output logic [11:0] mem_adr,
    output logic [11:0] mem_din,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] ST_WAIT_LEADER = 3'd0;
    localparam logic [2:0] ST_LEADER      = 3'd1;
    localparam logic [2:0] ST_HI          = 3'd2;
    localparam logic [2:0] ST_LO          = 3'd3;
    localparam logic [2:0] ST_DONE        = 3'd4;
    localparam logic [2:0] ST_ERR         = 3'd5;

    logic [2:0]  state;
    logic [7:0]  b1;
    logic [11:0] load_adr;
    logic [11:0] sum;
    logic        pend_valid;
    logic [11:0] pend_word;
    logic [11:0] pend_adr;
    logic [11:0] pend_frames;
    logic [3:0]  hold_cnt;

    logic        is_leader;
    logic        is_frame;
    logic        is_second;
    logic [11:0] pair_word;
    logic [11:0] pair_frames;
    logic [11:0] commit_frames;

    always_comb begin
        is_leader     = (rx_data == 8'h80);
        is_frame      = ~rx_data[7];
        is_second     = (rx_data[7:6] == 2'b00);
        pair_word     = {b1[5:0], rx_data[5:0]};
        pair_frames   = {4'd0, b1} + {4'd0, rx_data};
        commit_frames = pend_valid ? pend_frames : 12'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_WAIT_LEADER;
            b1          <= 8'd0;
            load_adr    <= 12'd0;
            sum         <= 12'd0;
            pend_valid  <= 1'b0;
            pend_word   <= 12'd0;
            pend_adr    <= 12'd0;
            pend_frames <= 12'd0;
            hold_cnt    <= HOLD;
            mem_we      <= 1'b0;
            mem_adr     <= 12'd0;
            mem_din     <= 12'd0;
            cpu_reset   <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (BYPASS || state == ST_DONE) begin
                // Terminal count of 1 releases the core so the release lands HOLD cycles after entry.
                state <= ST_DONE;
                done  <= 1'b1;
                if (hold_cnt == 4'd1) begin
                    cpu_reset <= 1'b0;
                    hold_cnt  <= 4'd0;
                end else if (hold_cnt != 4'd0) begin
                    hold_cnt <= hold_cnt - 4'd1;
                end
            end else if (rx_valid) begin
                case (state)
                    ST_WAIT_LEADER: begin
                        if (is_leader) state <= ST_LEADER;
                    end
                    ST_LEADER, ST_HI: begin
                        if (is_frame) begin
                            b1    <= rx_data;
                            state <= ST_LO;
                        end else if (is_leader && state == ST_HI) begin
                            // The last pending word is the checksum itself and is never written.
                            if (pend_valid && pend_word == sum) begin
                                state    <= ST_DONE;
                                done     <= 1'b1;
                                hold_cnt <= HOLD;
                            end else begin
                                state <= ST_ERR;
                                error <= 1'b1;
                            end
                        end
                    end
                    ST_LO: begin
                        if (!is_second) begin
                            state <= ST_ERR;
                            error <= 1'b1;
                        end else begin
                            if (pend_valid) begin
                                mem_we  <= 1'b1;
                                mem_adr <= pend_adr;
                                mem_din <= pend_word;
                            end
                            if (b1[6]) begin
                                load_adr   <= pair_word;
                                sum        <= sum + commit_frames + pair_frames;
                                pend_valid <= 1'b0;
                            end else begin
                                sum         <= sum + commit_frames;
                                pend_valid  <= 1'b1;
                                pend_word   <= pair_word;
                                pend_adr    <= load_adr;
                                pend_frames <= pair_frames;
                                load_adr    <= load_adr + 12'd1;
                            end
                            state <= ST_HI;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bin_loader.sv
// Scoreboard bench for bin_loader: directed tapes push expected writes, a monitor pops
// and compares every mem_we; a second instance exercises BYPASS.
module tb_bin_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;

    logic        mem_we, cpu_reset, done, error;
    logic [11:0] mem_adr, mem_din;
    logic        mem_we_b, cpu_reset_b, done_b, error_b;
    logic [11:0] mem_adr_b, mem_din_b;

    bin_loader #(.BYPASS(1'b0), .HOLD(4'd4)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_din(mem_din),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    bin_loader #(.BYPASS(1'b1), .HOLD(4'd4)) dut_b (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_we(mem_we_b), .mem_adr(mem_adr_b), .mem_din(mem_din_b),
        .cpu_reset(cpu_reset_b), .done(done_b), .error(error_b)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  tape[$];
    int          cyc = 0;
    int          t_done = -1;
    int          t_rel = -1;
    logic        done_q = 1'b0;
    logic        cpu_q = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic sb_write();
        logic [23:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write actual=adr %h din %h required=no write", mem_adr, mem_din);
        end else begin
            e = exp_q.pop_front();
            if (mem_adr !== e[23:12] || mem_din !== e[11:0]) begin
                failures++;
                $display("FAIL write actual=adr %h din %h required=adr %h din %h",
                         mem_adr, mem_din, e[23:12], e[11:0]);
            end
        end
        chk("write_while_core_held", {31'd0, cpu_reset}, 32'd1);
    endtask

    task automatic sb_bypass_write();
        checks++;
        failures++;
        $display("FAIL bypass_write actual=adr %h din %h required=no write", mem_adr_b, mem_din_b);
    endtask

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            t_done <= -1;
            t_rel  <= -1;
        end else begin
            if (done && !done_q) t_done <= cyc;
            if (!cpu_reset && cpu_q) t_rel <= cyc;
        end
        done_q <= done;
        cpu_q  <= cpu_reset;
        if (mem_we) sb_write();
        if (mem_we_b) sb_bypass_write();
    end

    task automatic expect_write(input logic [11:0] adr, input logic [11:0] din);
        exp_q.push_back({adr, din});
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic send_tape();
        foreach (tape[i]) send(tape[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rx_valid = 1'b0;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_good(input string tag);
        chk({tag, "_writes_seen"}, exp_q.size(), 0);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
        chk({tag, "_hold_cycles"}, t_rel - t_done, 4);
    endtask

    task automatic check_bad(input string tag);
        chk({tag, "_writes_seen"}, exp_q.size(), 0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd1);
        chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    endtask

    initial begin
        int k;
        do_reset();
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_adr", {20'd0, mem_adr}, 32'd0);
        chk("rst_mem_din", {20'd0, mem_din}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("bypass_rst_done", {31'd0, done_b}, 32'd0);

        // Bypass instance: released four edges after reset goes low.
        k = 0;
        @(posedge clk);
        while (cpu_reset_b && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("bypass_release_cycles", k, 4);
        chk("bypass_done", {31'd0, done_b}, 32'd1);

        // Minimal tape: origin 080, data F02, checksum 080.
        expect_write(12'h080, 12'hF02);
        tape = '{8'h80, 8'h80, 8'h80, 8'h42, 8'h00, 8'h3C, 8'h02, 8'h02, 8'h00, 8'h80};
        send_tape();
        idle(10);
        check_good("minimal");

        // Bad checksum 081 vs sum 080.
        do_reset();
        expect_write(12'h080, 12'hF02);
        tape = '{8'h80, 8'h80, 8'h80, 8'h42, 8'h00, 8'h3C, 8'h02, 8'h02, 8'h01, 8'h80};
        send_tape();
        idle(10);
        check_bad("badsum");
        chk("badsum_adr_held", {20'd0, mem_adr}, 32'h080);
        chk("badsum_din_held", {20'd0, mem_din}, 32'hF02);

        // Address wrap: origin FFF, data 001, 002; sum = BE+01+02 = 0C1.
        do_reset();
        expect_write(12'hFFF, 12'h001);
        expect_write(12'h000, 12'h002);
        tape = '{8'h80, 8'h80, 8'h7F, 8'h3F, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03, 8'h01, 8'h80};
        send_tape();
        idle(10);
        check_good("wrap");

        // Rubout/field bytes ignored between frames; 0x80 between b1 and b2 is an error.
        do_reset();
        expect_write(12'h080, 12'hF02);
        tape = '{8'h80, 8'h80, 8'h42, 8'h00, 8'hFF, 8'hC8, 8'h3C, 8'h02, 8'hFF, 8'hC8,
                 8'h00, 8'h05, 8'h01, 8'h80, 8'h00, 8'h00, 8'h80};
        send_tape();
        idle(10);
        check_bad("format");

        // Reset after the first data pair: pending word must be dropped.
        do_reset();
        tape = '{8'h80, 8'h80, 8'h42, 8'h00, 8'h3C, 8'h02};
        send_tape();
        do_reset();
        idle(6);
        chk("midreset_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_error", {31'd0, error}, 32'd0);
        chk("midreset_mem_adr", {20'd0, mem_adr}, 32'd0);
        chk("midreset_mem_din", {20'd0, mem_din}, 32'd0);
        chk("midreset_no_write", exp_q.size(), 0);

        expect_write(12'h080, 12'hF02);
        tape = '{8'h80, 8'h80, 8'h80, 8'h42, 8'h00, 8'h3C, 8'h02, 8'h02, 8'h00, 8'h80};
        send_tape();
        idle(10);
        check_good("reload");

        chk("bypass_final_cpu_reset", {31'd0, cpu_reset_b}, 32'd0);
        chk("bypass_final_done", {31'd0, done_b}, 32'd1);
        chk("bypass_final_error", {31'd0, error_b}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
